// File: rtl/rgb2lab_pkg.sv
// Shared definitions for the RGB->lab stream controller.
// Contents: pixel and lab word widths, FSM state encoding, and the default
// frame size (640x480).
package rgb2lab_pkg;

  localparam int PIX_W         = 8;
  localparam int LAB_W         = 16;
  localparam int FRAME_PIX_DEF = 307200;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_OUT    = 2'd2
  } state_t;

endpackage

// File: rtl/rgb2lab_stream_ctrl_pixel_frame_counter.sv
// pixel_frame_counter: position of the current result within its frame.
// Ports:
//   i_clk, i_rst (sync, active-low)
//   i_inc        one output transfer completed this cycle
//   o_pix_cnt    index of the result being presented within its frame
//   o_last       o_pix_cnt is the final pixel of the frame
//   o_frame_cnt  completed frames, wraps 255->0
module pixel_frame_counter
  import rgb2lab_pkg::*;
#(
  parameter int FRAME_PIX = FRAME_PIX_DEF,
  parameter int PIX_CNT_W = 19
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_inc,
  output logic [PIX_CNT_W-1:0] o_pix_cnt,
  output logic                 o_last,
  output logic [7:0]           o_frame_cnt
);

  localparam logic [PIX_CNT_W-1:0] LAST_IDX = PIX_CNT_W'(FRAME_PIX - 1);

  assign o_last = (o_pix_cnt == LAST_IDX);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_pix_cnt   <= '0;
      o_frame_cnt <= '0;
    end else if (i_inc) begin
      if (o_last) begin
        o_pix_cnt   <= '0;
        o_frame_cnt <= o_frame_cnt + 8'd1;
      end else begin
        o_pix_cnt   <= o_pix_cnt + PIX_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rgb2lab_stream_ctrl.sv
// rgb2lab_stream_ctrl: sequences pixels through the combinational RGB->lab
// converter. A pixel accepted on the input handshake is held on o_conv_R/G/B
// for SETTLE_CYC cycles (multicycle path budget), the converter result is
// captured bit-exact into o_l/o_a/o_b and offered on the output handshake.
// Ports:
//   i_clk, i_rst (sync, active-low)
//   i_valid/o_ready, i_R/i_G/i_B         input pixel handshake
//   o_conv_R/G/B                          registered converter inputs
//   i_conv_l/a/b                          converter outputs (3.13)
//   o_valid/i_ready, o_l/o_a/o_b          result handshake (3.13)
//   o_eof                                 result is last pixel of frame
//   o_frame_cnt                           completed frames, wraps 255->0
//   o_busy                                controller not idle
// Optional build macro RGB2LAB_STATS_EN adds per-frame sum of o_l:
//   o_frame_l_sum, o_stats_valid (one-cycle pulse after the eof transfer).
module rgb2lab_stream_ctrl
  import rgb2lab_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int FRAME_PIX  = FRAME_PIX_DEF,
  parameter int PIX_CNT_W  = 19
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [PIX_W-1:0] i_R,
  input  logic [PIX_W-1:0] i_G,
  input  logic [PIX_W-1:0] i_B,
  output logic [PIX_W-1:0] o_conv_R,
  output logic [PIX_W-1:0] o_conv_G,
  output logic [PIX_W-1:0] o_conv_B,
  input  logic [LAB_W-1:0] i_conv_l,
  input  logic [LAB_W-1:0] i_conv_a,
  input  logic [LAB_W-1:0] i_conv_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [LAB_W-1:0] o_l,
  output logic [LAB_W-1:0] o_a,
  output logic [LAB_W-1:0] o_b,
  output logic             o_eof,
  output logic [7:0]       o_frame_cnt,
  output logic             o_busy
`ifdef RGB2LAB_STATS_EN
  ,
  output logic [PIX_CNT_W+15:0] o_frame_l_sum,
  output logic                  o_stats_valid
`endif
);

  generate
    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
      $error("rgb2lab_stream_ctrl: SETTLE_CYC must be in 1..15");
    end
    if (FRAME_PIX < 2 || longint'(FRAME_PIX) > (longint'(1) << PIX_CNT_W)) begin : g_bad_frame
      $error("rgb2lab_stream_ctrl: FRAME_PIX must be in 2..2^PIX_CNT_W");
    end
  endgenerate

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t     state, state_nxt;
  logic [3:0] settle_cnt;
  logic       accept, xfer, capture, last_pix;
  // Only the last-pixel flag is needed here; the index itself stays internal.
  logic [PIX_CNT_W-1:0] pix_idx_unused;

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    case (state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_nxt = S_OUT;
      end
      S_OUT: begin
        // Completing a result frees the converter inputs in the same cycle.
        o_ready = i_ready;
        if (i_ready) state_nxt = i_valid ? S_SETTLE : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!i_rst) o_ready = 1'b0;
  end

  assign accept  = i_valid & o_ready;
  assign xfer    = o_valid & i_ready;
  assign capture = (state == S_SETTLE) && (settle_cnt == SETTLE_LAST);
  assign o_busy  = (state != S_IDLE);
  assign o_eof   = o_valid & last_pix;

  // Stage boundary: accept -> converter inputs held, settle window counted
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      o_conv_R   <= '0;
      o_conv_G   <= '0;
      o_conv_B   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        o_conv_R   <= i_R;
        o_conv_G   <= i_G;
        o_conv_B   <= i_B;
        settle_cnt <= '0;
      end else if (state == S_SETTLE) begin
        settle_cnt <= settle_cnt + 4'd1;
      end
    end
  end

  // Stage boundary: settled converter output -> result registers
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_l     <= '0;
      o_a     <= '0;
      o_b     <= '0;
      o_valid <= 1'b0;
    end else begin
      if (capture) begin
        o_l <= i_conv_l;
        o_a <= i_conv_a;
        o_b <= i_conv_b;
      end
      o_valid <= (state_nxt == S_OUT);
    end
  end

  pixel_frame_counter #(
    .FRAME_PIX (FRAME_PIX),
    .PIX_CNT_W (PIX_CNT_W)
  ) u_pix_cnt (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_inc       (xfer),
    .o_pix_cnt   (pix_idx_unused),
    .o_last      (last_pix),
    .o_frame_cnt (o_frame_cnt)
  );

`ifdef RGB2LAB_STATS_EN
  logic [PIX_CNT_W+15:0] l_acc;
  logic [PIX_CNT_W+15:0] l_acc_nxt;

  assign l_acc_nxt = l_acc + {{PIX_CNT_W{1'b0}}, o_l};

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      l_acc         <= '0;
      o_frame_l_sum <= '0;
      o_stats_valid <= 1'b0;
    end else begin
      o_stats_valid <= 1'b0;
      if (xfer) begin
        if (last_pix) begin
          o_frame_l_sum <= l_acc_nxt;
          l_acc         <= '0;
          o_stats_valid <= 1'b1;
        end else begin
          l_acc <= l_acc_nxt;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_rgb2lab_stream_ctrl.sv
module tb_rgb2lab_stream_ctrl;
  localparam int SC  = 2;
  localparam int FP  = 4;
  localparam int PCW = 19;

  logic clk = 1'b0;
  logic rst_n, i_valid, i_ready, o_ready, o_valid, o_eof, o_busy;
  logic [7:0] ir, ig, ib, cr, cg, cb, o_frame_cnt;
  logic [15:0] cl, ca, cbb, o_l, o_a, o_b;
`ifdef RGB2LAB_STATS_EN
  logic [PCW+15:0] o_frame_l_sum;
  logic            o_stats_valid;
`endif

  always #5 clk = ~clk;

  rgb2lab_stream_ctrl #(.SETTLE_CYC(SC), .FRAME_PIX(FP), .PIX_CNT_W(PCW)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_R(ir), .i_G(ig), .i_B(ib),
    .o_conv_R(cr), .o_conv_G(cg), .o_conv_B(cb),
    .i_conv_l(cl), .i_conv_a(ca), .i_conv_b(cbb),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_l(o_l), .o_a(o_a), .o_b(o_b),
    .o_eof(o_eof), .o_frame_cnt(o_frame_cnt), .o_busy(o_busy)
`ifdef RGB2LAB_STATS_EN
    , .o_frame_l_sum(o_frame_l_sum), .o_stats_valid(o_stats_valid)
`endif
  );

  // Stand-in converter: an arbitrary bit-exact function of the held inputs.
  function automatic logic [15:0] f_l(logic [7:0] r, logic [7:0] g, logic [7:0] b);
    return {r, g};
  endfunction
  function automatic logic [15:0] f_a(logic [7:0] r, logic [7:0] g, logic [7:0] b);
    return {g, b};
  endfunction
  function automatic logic [15:0] f_b(logic [7:0] r, logic [7:0] g, logic [7:0] b);
    return {b, r} ^ 16'h5a5a;
  endfunction

  assign cl  = f_l(cr, cg, cb);
  assign ca  = f_a(cr, cg, cb);
  assign cbb = f_b(cr, cg, cb);

  typedef struct {
    logic [7:0] r, g, b;
    int         acc_edge;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   k     = 0;   // results transferred since reset
  bit   rand_rdy = 0;
`ifdef RGB2LAB_STATS_EN
  longint lsum = 0, held = 0;
  bit     stats_due = 0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      i_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor / reference model: evaluated between edges, predicts the next edge.
  always @(negedge clk) begin
    bit ev, rdy_e;
    ent_t e;
    ev    = (q.size() > 0) && (cyc >= q[0].acc_edge + SC);
    rdy_e = rst_n && ((q.size() == 0) || (ev && i_ready));
    chk("o_ready", 64'(o_ready), 64'(rdy_e));
    chk("o_valid", 64'(o_valid), 64'(ev));
    chk("o_busy", 64'(o_busy), 64'(q.size() > 0));
    chk("o_eof", 64'(o_eof), 64'(ev && (k % FP == FP - 1)));
    chk("o_frame_cnt", 64'(o_frame_cnt), 64'((k / FP) % 256));
    if (q.size() > 0) begin
      e = q[0];
      chk("o_conv_RGB", {40'd0, cr, cg, cb}, {40'd0, e.r, e.g, e.b});
      if (ev) begin
        chk("o_l", 64'(o_l), 64'(f_l(e.r, e.g, e.b)));
        chk("o_a", 64'(o_a), 64'(f_a(e.r, e.g, e.b)));
        chk("o_b", 64'(o_b), 64'(f_b(e.r, e.g, e.b)));
      end
    end
`ifdef RGB2LAB_STATS_EN
    chk("o_stats_valid", 64'(o_stats_valid), 64'(stats_due));
    chk("o_frame_l_sum", 64'(o_frame_l_sum), 64'(held));
    stats_due = 0;
`endif
    if (!rst_n) begin
      q.delete();
      k = 0;
`ifdef RGB2LAB_STATS_EN
      lsum = 0;
      held = 0;
`endif
    end else begin
      if (ev && i_ready) begin
        e = q.pop_front();
`ifdef RGB2LAB_STATS_EN
        if (k % FP == FP - 1) begin
          held      = lsum + longint'(f_l(e.r, e.g, e.b));
          lsum      = 0;
          stats_due = 1;
        end else begin
          lsum += longint'(f_l(e.r, e.g, e.b));
        end
`endif
        k++;
      end
      if (i_valid && rdy_e) begin
        e.r = ir; e.g = ig; e.b = ib;
        e.acc_edge = cyc + 1;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bit ok;
    ok = 0;
    i_valid = 1'b1; ir = r; ig = g; ib = b;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (o_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout actual=no_accept required=accept at %0t", $time);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #2;
      if (q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL drain_timeout actual=%0d required=0 pending at %0t", q.size(), $time);
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    i_valid = 1'b0; i_ready = 1'b1; ir = '0; ig = '0; ib = '0;
    // reset, then reset again in the middle of a settle window
    do_reset(3);
    send(8'd10, 8'd20, 8'd30);
    do_reset(3);
    // single white pixel
    send(8'd255, 8'd255, 8'd255);
    drain();
    // backpressure with a new pixel waiting
    i_ready = 1'b0;
    send(8'd1, 8'd2, 8'd3);
    i_valid = 1'b1; ir = 8'd4; ig = 8'd5; ib = 8'd6;
    repeat (12) @(posedge clk);
    #1;
    i_ready = 1'b1;
    send(8'd4, 8'd5, 8'd6);
    drain();
    // back-to-back streaming
    for (int i = 0; i < 8; i++)
      send(8'($urandom), 8'($urandom), 8'($urandom));
    drain();
    // frame-aligned known l values for the frame sum
    do_reset(2);
    for (int i = 1; i <= 4; i++)
      send(8'(i), 8'd0, 8'(i * 7));
    drain();
`ifdef RGB2LAB_STATS_EN
    chk("frame_l_sum_const", 64'(o_frame_l_sum), 64'h0A00);
`endif
    // long random run with random backpressure and gaps (frame count wraps)
    rand_rdy = 1;
    for (int i = 0; i < 1100; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(8'($urandom), 8'($urandom), 8'($urandom));
    end
    rand_rdy = 0;
    @(posedge clk);
    #2;
    i_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
